// File: rtl/ialu_pipe.sv
// Pipelined integer ALU (RV64I/RV32I ops, optional W-variants) with spec-mask kill/resolve and wakeup.
// Result appears STAGES cycles after accept; valid/ready stalls collapse bubbles, in_ready follows stage 1.
module ialu_pipe #(
  parameter int XLEN        = 64,
  parameter int STAGES      = 2,
  parameter int SPEC_STATES = 4,
  parameter int PRD_W       = 7,
  parameter int ROB_W       = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   kill_en,
  input  logic [SPEC_STATES-1:0] kill_mask,
  input  logic                   resolve_en,
  input  logic [SPEC_STATES-1:0] resolve_mask,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_op1,
  input  logic [XLEN-1:0]        in_op2,
  input  logic [3:0]             in_alu_op,
  input  logic                   in_is_word,
  input  logic [SPEC_STATES-1:0] in_killmask,
  input  logic [PRD_W-1:0]       in_prd,
  input  logic [ROB_W-1:0]       in_rob,
  input  logic                   in_reg_we,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_value,
  output logic [PRD_W-1:0]       out_prd,
  output logic [ROB_W-1:0]       out_rob,
  output logic                   out_reg_we,
  output logic                   wake_valid,
  output logic [PRD_W-1:0]       wake_prd,
  output logic [ROB_W-1:0]       wake_rob
);
  localparam int LAST = STAGES - 1;

  function automatic logic hit_f(input logic en, input logic [SPEC_STATES-1:0] m,
                                 input logic [SPEC_STATES-1:0] k);
    return en & (|(m & k));
  endfunction

  logic              word_op, uses_w;
  logic [5:0]        shamt;
  logic [31:0]       w_res;
  logic [XLEN-1:0]   f_res, alu_res;

  always_comb begin
    word_op = (XLEN == 64) && in_is_word;
    shamt   = (XLEN == 64 && !in_is_word) ? in_op2[5:0] : {1'b0, in_op2[4:0]};
    w_res   = '0;
    f_res   = '0;
    uses_w  = 1'b0;
    case (in_alu_op)
      4'd0: begin f_res = in_op1 + in_op2; w_res = in_op1[31:0] + in_op2[31:0]; uses_w = 1'b1; end
      4'd1: begin f_res = in_op1 - in_op2; w_res = in_op1[31:0] - in_op2[31:0]; uses_w = 1'b1; end
      4'd2: begin f_res = in_op1 << shamt; w_res = in_op1[31:0] << shamt[4:0]; uses_w = 1'b1; end
      4'd3: f_res = {{(XLEN-1){1'b0}}, $signed(in_op1) < $signed(in_op2)};
      4'd4: f_res = {{(XLEN-1){1'b0}}, in_op1 < in_op2};
      4'd5: f_res = in_op1 ^ in_op2;
      4'd6: begin f_res = in_op1 >> shamt; w_res = in_op1[31:0] >> shamt[4:0]; uses_w = 1'b1; end
      4'd7: begin
        f_res  = XLEN'($signed(in_op1) >>> shamt);
        w_res  = 32'($signed(in_op1[31:0]) >>> shamt[4:0]);
        uses_w = 1'b1;
      end
      4'd8: f_res = in_op1 | in_op2;
      4'd9: f_res = in_op1 & in_op2;
      default: ;
    endcase
    // W-variants sign-extend the 32-bit result to the full datapath
    alu_res = (word_op && uses_w) ? XLEN'(signed'(w_res)) : f_res;
  end

  logic [STAGES-1:0]      vld_q, vld_d, ld, src_vld, we_q, we_d, src_we;
  logic [SPEC_STATES-1:0] mask_q [STAGES];
  logic [SPEC_STATES-1:0] mask_d [STAGES];
  logic [SPEC_STATES-1:0] src_mask [STAGES];
  logic [XLEN-1:0]        val_q [STAGES];
  logic [XLEN-1:0]        val_d [STAGES];
  logic [XLEN-1:0]        src_val [STAGES];
  logic [PRD_W-1:0]       prd_q [STAGES];
  logic [PRD_W-1:0]       prd_d [STAGES];
  logic [PRD_W-1:0]       src_prd [STAGES];
  logic [ROB_W-1:0]       rob_q [STAGES];
  logic [ROB_W-1:0]       rob_d [STAGES];
  logic [ROB_W-1:0]       src_rob [STAGES];
  logic [SPEC_STATES-1:0] clr_mask;
  logic                   woken_q, woken_d;

  always_comb begin
    logic go;
    // A stage loads when it is empty or its occupant moves on downstream
    go = out_ready;
    for (int k = LAST; k >= 0; k--) begin
      ld[k] = ~vld_q[k] | go;
      go    = ld[k];
    end
    in_ready = go | flush;
    clr_mask = resolve_en ? resolve_mask : '0;

    src_vld[0]  = in_valid & in_ready;
    src_mask[0] = in_killmask;
    src_val[0]  = alu_res;
    src_prd[0]  = in_prd;
    src_rob[0]  = in_rob;
    src_we[0]   = in_reg_we;
    for (int k = 1; k < STAGES; k++) begin
      src_vld[k]  = vld_q[k-1];
      src_mask[k] = mask_q[k-1];
      src_val[k]  = val_q[k-1];
      src_prd[k]  = prd_q[k-1];
      src_rob[k]  = rob_q[k-1];
      src_we[k]   = we_q[k-1];
    end

    // Kill is tested on the pre-resolve mask so it wins over a same-cycle resolve
    for (int k = 0; k < STAGES; k++) begin
      vld_d[k]  = vld_q[k] & ~flush & ~hit_f(kill_en, mask_q[k], kill_mask);
      mask_d[k] = mask_q[k] & ~clr_mask;
      val_d[k]  = val_q[k];
      prd_d[k]  = prd_q[k];
      rob_d[k]  = rob_q[k];
      we_d[k]   = we_q[k];
      if (ld[k]) begin
        vld_d[k]  = src_vld[k] & ~flush & ~hit_f(kill_en, src_mask[k], kill_mask);
        mask_d[k] = src_mask[k] & ~clr_mask;
        val_d[k]  = src_val[k];
        prd_d[k]  = src_prd[k];
        rob_d[k]  = src_rob[k];
        we_d[k]   = src_we[k];
      end
    end
  end

  always_comb begin
    out_valid  = vld_q[LAST] & ~rst & ~flush & ~hit_f(kill_en, mask_q[LAST], kill_mask);
    out_value  = out_valid ? val_q[LAST] : '0;
    out_prd    = out_valid ? prd_q[LAST] : '0;
    out_rob    = out_valid ? rob_q[LAST] : '0;
    out_reg_we = out_valid & we_q[LAST];
    wake_valid = out_valid & we_q[LAST] & ~woken_q;
    wake_prd   = wake_valid ? prd_q[LAST] : '0;
    wake_rob   = wake_valid ? rob_q[LAST] : '0;
    woken_d    = (ld[LAST] | flush) ? 1'b0 : (woken_q | out_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      woken_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) mask_q[k] <= '0;
    end else begin
      vld_q   <= vld_d;
      woken_q <= woken_d;
      for (int k = 0; k < STAGES; k++) mask_q[k] <= mask_d[k];
    end
  end

  always_ff @(posedge clk) begin
    we_q <= we_d;
    for (int k = 0; k < STAGES; k++) begin
      val_q[k] <= val_d[k];
      prd_q[k] <= prd_d[k];
      rob_q[k] <= rob_d[k];
    end
  end

endmodule

// File: tb/tb_ialu_pipe.sv
// Scoreboard bench for ialu_pipe: a 64-bit/2-stage and a 32-bit/1-stage instance share stimulus buses.
module tb_ialu_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4,
                         XOR = 4'd5, SRL = 4'd6, SRA = 4'd7, OR = 4'd8, AND = 4'd9;

  logic        rst = 1'b1, flush = 1'b0, kill_en = 1'b0, resolve_en = 1'b0;
  logic [3:0]  kill_mask = '0, resolve_mask = '0, alu_op = '0, kmask = '0;
  logic [63:0] op1 = '0, op2 = '0;
  logic        is_word = 1'b0, reg_we = 1'b0;
  logic [6:0]  prd = '0;
  logic [5:0]  rob = '0;

  logic        a_iv = 1'b0, a_or = 1'b1, a_ir, a_ov, a_we, a_wv;
  logic [63:0] a_val;
  logic [6:0]  a_prd, a_wprd;
  logic [5:0]  a_rob, a_wrob;
  logic        b_iv = 1'b0, b_or = 1'b1, b_ir, b_ov, b_we, b_wv;
  logic [31:0] b_val;
  logic [6:0]  b_prd, b_wprd;
  logic [5:0]  b_rob, b_wrob;

  ialu_pipe #(.XLEN(64), .STAGES(2)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .kill_en(kill_en), .kill_mask(kill_mask),
    .resolve_en(resolve_en), .resolve_mask(resolve_mask), .in_valid(a_iv), .in_ready(a_ir),
    .in_op1(op1), .in_op2(op2), .in_alu_op(alu_op), .in_is_word(is_word), .in_killmask(kmask),
    .in_prd(prd), .in_rob(rob), .in_reg_we(reg_we), .out_valid(a_ov), .out_ready(a_or),
    .out_value(a_val), .out_prd(a_prd), .out_rob(a_rob), .out_reg_we(a_we),
    .wake_valid(a_wv), .wake_prd(a_wprd), .wake_rob(a_wrob));

  ialu_pipe #(.XLEN(32), .STAGES(1)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .kill_en(kill_en), .kill_mask(kill_mask),
    .resolve_en(resolve_en), .resolve_mask(resolve_mask), .in_valid(b_iv), .in_ready(b_ir),
    .in_op1(op1[31:0]), .in_op2(op2[31:0]), .in_alu_op(alu_op), .in_is_word(is_word),
    .in_killmask(kmask), .in_prd(prd), .in_rob(rob), .in_reg_we(reg_we), .out_valid(b_ov),
    .out_ready(b_or), .out_value(b_val), .out_prd(b_prd), .out_rob(b_rob), .out_reg_we(b_we),
    .wake_valid(b_wv), .wake_prd(b_wprd), .wake_rob(b_wrob));

  typedef struct {
    logic [63:0] val;
    logic [6:0]  prd;
    logic [5:0]  rob;
    logic        we;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] x;
    logic [63:0] y;
    logic        w;
    logic [63:0] ev;
  } vec_t;

  exp_t qa[$];
  exp_t qb[$];
  bit   hw[2];
  int   n_chk = 0, n_pass = 0, cyc = 0;

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic mon(input int id, input logic ov, input logic ordy, input logic [63:0] val,
                     input logic [6:0] p, input logic [5:0] r, input logic we,
                     input logic wv, input logic [6:0] wp, input logic [5:0] wr);
    exp_t h;
    int   n;
    n = (id == 0) ? qa.size() : qb.size();
    if (!ov) begin
      chk($sformatf("idle_value%0d", id), val, 64'd0);
      chk($sformatf("idle_wake%0d", id), {63'd0, wv}, 64'd0);
    end else if (n == 0) begin
      n_chk++;
      $display("FAIL unexpected_out%0d: got value 0x%0h prd %0d, expected no output", id, val, p);
    end else begin
      if (id == 0) h = qa[0];
      else h = qb[0];
      chk($sformatf("value%0d", id), val, h.val);
      chk($sformatf("prd%0d", id), {57'd0, p}, {57'd0, h.prd});
      chk($sformatf("rob%0d", id), {58'd0, r}, {58'd0, h.rob});
      chk($sformatf("reg_we%0d", id), {63'd0, we}, {63'd0, h.we});
      chk($sformatf("wake_valid%0d", id), {63'd0, wv}, {63'd0, h.we && !hw[id]});
      if (wv) begin
        chk($sformatf("wake_prd%0d", id), {57'd0, wp}, {57'd0, h.prd});
        chk($sformatf("wake_rob%0d", id), {58'd0, wr}, {58'd0, h.rob});
        hw[id] = 1'b1;
      end
      if (ordy) begin
        if (h.lat > 0) chk($sformatf("latency%0d", id), 64'(cyc + 1 - h.acc), 64'(h.lat));
        chk($sformatf("wake_count%0d", id), {63'd0, hw[id]}, {63'd0, h.we});
        hw[id] = 1'b0;
        if (id == 0) void'(qa.pop_front());
        else void'(qb.pop_front());
      end
    end
  endtask

  always @(negedge clk) if (!rst) mon(0, a_ov, a_or, a_val, a_prd, a_rob, a_we, a_wv, a_wprd, a_wrob);
  always @(negedge clk) if (!rst) mon(1, b_ov, b_or, {32'd0, b_val}, b_prd, b_rob, b_we, b_wv, b_wprd, b_wrob);

  task automatic issue(input int id, input logic [3:0] op, input logic [63:0] x, input logic [63:0] y,
                       input logic w, input logic [3:0] m, input logic [6:0] p, input logic [5:0] r,
                       input logic we, input logic [63:0] ev, input bit push, input int lat);
    bit   rdy;
    bit   done;
    exp_t e;
    done = 1'b0;
    alu_op = op; op1 = x; op2 = y; is_word = w; kmask = m; prd = p; rob = r; reg_we = we;
    if (id == 0) a_iv = 1'b1;
    else b_iv = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      rdy = (id == 0) ? a_ir : b_ir;
      @(posedge clk);
      #1;
      if (rdy) done = 1'b1;
    end
    a_iv = 1'b0;
    b_iv = 1'b0;
    if (!done) begin
      n_chk++;
      $display("FAIL accept_timeout%0d: got no in_ready in 50 cycles, expected acceptance", id);
    end else if (push) begin
      e.val = ev; e.prd = p; e.rob = r; e.we = we; e.lat = lat; e.acc = cyc;
      if (id == 0) qa.push_back(e);
      else qb.push_back(e);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && (qa.size() != 0 || qb.size() != 0); t++) @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  vec_t at[18];
  vec_t bt[8];

  initial begin
    at[0]  = '{ADD,  64'h7FFF_FFFF, 64'd1, 1'b1, 64'hFFFF_FFFF_8000_0000};
    at[1]  = '{SRA,  64'h8000_0000_0000_0000, 64'd63, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
    at[2]  = '{SRL,  64'h8000_0000, 64'd0, 1'b1, 64'hFFFF_FFFF_8000_0000};
    at[3]  = '{SLTU, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd1};
    at[4]  = '{SLT,  64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0};
    at[5]  = '{SUB,  64'd5, 64'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE};
    at[6]  = '{SUB,  64'h1_0000_0000, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
    at[7]  = '{SLL,  64'd1, 64'd65, 1'b0, 64'd2};
    at[8]  = '{SLL,  64'd1, 64'd31, 1'b1, 64'hFFFF_FFFF_8000_0000};
    at[9]  = '{SRA,  64'h8000_0000, 64'd4, 1'b1, 64'hFFFF_FFFF_F800_0000};
    at[10] = '{SRL,  64'h8000_0000_0000_0000, 64'd4, 1'b0, 64'h0800_0000_0000_0000};
    at[11] = '{XOR,  64'hF0F0, 64'hFF00, 1'b0, 64'h0FF0};
    at[12] = '{OR,   64'hF0F0, 64'h0F0F, 1'b0, 64'hFFFF};
    at[13] = '{AND,  64'hF0F0, 64'hFF00, 1'b0, 64'hF000};
    at[14] = '{4'd13, 64'd5, 64'd6, 1'b0, 64'd0};
    at[15] = '{ADD,  64'h7FFF_FFFF, 64'd1, 1'b0, 64'h8000_0000};
    at[16] = '{SLT,  64'hFFFF_FFFF, 64'd0, 1'b1, 64'd0};
    at[17] = '{XOR,  64'h1_0000_0000, 64'd0, 1'b1, 64'h1_0000_0000};

    bt[0] = '{ADD,  64'hFFFF_FFFF, 64'd1, 1'b0, 64'd0};
    bt[1] = '{SLL,  64'd1, 64'd33, 1'b0, 64'd2};
    bt[2] = '{SRA,  64'h8000_0000, 64'd4, 1'b0, 64'hF800_0000};
    bt[3] = '{ADD,  64'h7FFF_FFFF, 64'd1, 1'b1, 64'h8000_0000};
    bt[4] = '{SLTU, 64'd1, 64'hFFFF_FFFF, 1'b0, 64'd1};
    bt[5] = '{SLT,  64'd1, 64'hFFFF_FFFF, 1'b0, 64'd0};
    bt[6] = '{SRL,  64'h8000_0000, 64'd35, 1'b0, 64'h1000_0000};
    bt[7] = '{SUB,  64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF};

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid_a", {63'd0, a_ov}, 64'd0);
    chk("rst_wake_a", {63'd0, a_wv}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready_a", {63'd0, a_ir}, 64'd1);
    chk("post_rst_in_ready_b", {63'd0, b_ir}, 64'd1);
    @(posedge clk);
    #1;

    // Back-to-back ALU vectors, no stalls, latency checked
    for (int i = 0; i < 18; i++)
      issue(0, at[i].op, at[i].x, at[i].y, at[i].w, 4'b0, 7'(i + 1), 6'(i + 10), i != 15,
            at[i].ev, 1'b1, 2);
    drain();

    // Backpressure: two uops fill the pipe, then in_ready must drop
    a_or = 1'b0;
    issue(0, ADD, 64'd100, 64'd1, 1'b0, 4'b0, 7'd50, 6'd50, 1'b1, 64'd101, 1'b1, 0);
    issue(0, ADD, 64'd101, 64'd1, 1'b0, 4'b0, 7'd51, 6'd51, 1'b1, 64'd102, 1'b1, 0);
    @(negedge clk);
    chk("in_ready_full", {63'd0, a_ir}, 64'd0);
    @(posedge clk);
    #1 a_or = 1'b1;
    issue(0, ADD, 64'd102, 64'd1, 1'b0, 4'b0, 7'd52, 6'd52, 1'b1, 64'd103, 1'b1, 0);
    issue(0, ADD, 64'd103, 64'd1, 1'b0, 4'b0, 7'd53, 6'd53, 1'b0, 64'd104, 1'b1, 0);
    drain();

    // Kill one stage while resolving the other, then the resolved uop survives a kill
    a_or = 1'b0;
    issue(0, ADD, 64'd1, 64'd2, 1'b0, 4'b0001, 7'd60, 6'd60, 1'b1, 64'd3, 1'b1, 0);
    issue(0, ADD, 64'd3, 64'd4, 1'b0, 4'b0010, 7'd61, 6'd61, 1'b1, 64'd7, 1'b0, 0);
    kill_en = 1'b1; kill_mask = 4'b0010; resolve_en = 1'b1; resolve_mask = 4'b0001;
    @(negedge clk);
    chk("kill_other_keeps_out", {63'd0, a_ov}, 64'd1);
    @(posedge clk);
    #1 kill_mask = 4'b0001; resolve_en = 1'b0;
    @(negedge clk);
    chk("resolved_survives", {63'd0, a_ov}, 64'd1);
    @(posedge clk);
    #1 kill_en = 1'b0; a_or = 1'b1;
    drain();

    // Kill of the last stage gates out_valid in the same cycle
    issue(0, ADD, 64'd9, 64'd9, 1'b0, 4'b0100, 7'd62, 6'd62, 1'b1, 64'd18, 1'b0, 0);
    @(posedge clk);
    #1 kill_en = 1'b1; kill_mask = 4'b0100;
    @(negedge clk);
    chk("kill_last_gates_out", {63'd0, a_ov}, 64'd0);
    @(posedge clk);
    #1 kill_en = 1'b0;

    // Incoming uop killed on accept; kill beats resolve on the same bit
    kill_en = 1'b1; kill_mask = 4'b1000;
    issue(0, ADD, 64'd1, 64'd1, 1'b0, 4'b1000, 7'd63, 6'd63, 1'b1, 64'd2, 1'b0, 0);
    kill_mask = 4'b0001; resolve_en = 1'b1; resolve_mask = 4'b0001;
    issue(0, ADD, 64'd2, 64'd2, 1'b0, 4'b0001, 7'd64, 6'd64, 1'b1, 64'd4, 1'b0, 0);
    kill_en = 1'b0; resolve_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Flush with a full pipe and a uop offered
    a_or = 1'b0;
    issue(0, ADD, 64'd5, 64'd5, 1'b0, 4'b0, 7'd70, 6'd70, 1'b1, 64'd10, 1'b0, 0);
    issue(0, ADD, 64'd6, 64'd6, 1'b0, 4'b0, 7'd71, 6'd71, 1'b1, 64'd12, 1'b0, 0);
    flush = 1'b1; a_iv = 1'b1;
    @(negedge clk);
    chk("in_ready_flush", {63'd0, a_ir}, 64'd1);
    chk("flush_gates_out", {63'd0, a_ov}, 64'd0);
    @(posedge clk);
    #1 flush = 1'b0; a_iv = 1'b0; a_or = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_flush_out_valid", {63'd0, a_ov}, 64'd0);
      chk("post_flush_wake", {63'd0, a_wv}, 64'd0);
    end
    @(posedge clk);
    #1;
    issue(0, SUB, 64'd50, 64'd8, 1'b0, 4'b0, 7'd72, 6'd72, 1'b1, 64'd42, 1'b1, 2);
    drain();

    // 32-bit single-stage instance
    for (int i = 0; i < 8; i++)
      issue(1, bt[i].op, bt[i].x, bt[i].y, bt[i].w, 4'b0, 7'(i + 80), 6'(i + 20), 1'b1,
            bt[i].ev, 1'b1, 1);
    drain();

    // Reset while a result is stalled at the output
    b_or = 1'b0;
    issue(1, ADD, 64'd5, 64'd6, 1'b0, 4'b0, 7'd90, 6'd30, 1'b1, 64'd11, 1'b1, 0);
    @(negedge clk);
    chk("stalled_visible_b", {63'd0, b_ov}, 64'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_drops_out_b", {63'd0, b_ov}, 64'd0);
    chk("rst_drops_wake_b", {63'd0, b_wv}, 64'd0);
    qb.delete();
    hw[1] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0; b_or = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_idle_b", {63'd0, b_ov}, 64'd0);
    end
    @(posedge clk);
    #1;

    drain();
    chk("qa_drained", 64'(qa.size()), 64'd0);
    chk("qb_drained", 64'(qb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
